// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and default sizing for the pipeline stall controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, ERROR} state_t;
  localparam int RA_W = 4;
  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the register a load in EX is about to write
module load_use_detect #(
  parameter int RA_W = pipe_ctrl_pkg::RA_W
) (
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd_addr,
  input  logic [RA_W-1:0] id_rn_addr,
  input  logic [RA_W-1:0] id_rm_addr,
  input  logic            id_rn_used,
  input  logic            id_rm_used,
  output logic            hazard
);
  assign hazard = ex_mem_read & ((id_rn_used & (id_rn_addr == ex_rd_addr)) |
                                 (id_rm_used & (id_rm_addr == ex_rd_addr)));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: per-stage enables, flushes and bubbles for the 5-stage pipeline
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RA_W        = pipe_ctrl_pkg::RA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rn_addr,
  input  logic [RA_W-1:0]  id_rm_addr,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic             ex_mem_read,
  input  logic [RA_W-1:0]  ex_rd_addr,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_bubble,
  output logic             dbg_halted,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic memwait, lu, active, go, hold;
  load_use_detect #(.RA_W(RA_W)) u_lud (
    .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr),
    .id_rn_addr(id_rn_addr),
    .id_rm_addr(id_rm_addr),
    .id_rn_used(id_rn_used),
    .id_rm_used(id_rm_used),
    .hazard(lu)
  );
  assign memwait = dmem_req & ~dmem_ready;
  // a single-step cycle while halted behaves exactly like a RUN cycle
  assign active = (state == RUN) | (state == MEM_WAIT) | ((state == HALTED) & dbg_step);
  assign go = ~reset & active;
  // a branch squashes the younger load-use stall, so the front end only holds when no branch
  assign hold = lu & ~ex_branch_taken;
  assign pc_en = go & ~memwait & ~hold;
  assign if_id_en = go & ~memwait & ~hold;
  assign if_id_flush = go & ~memwait & ex_branch_taken;
  assign id_ex_en = go & ~memwait;
  assign id_ex_bubble = go & ~memwait & (ex_branch_taken | lu);
  assign ex_mem_en = go & ~memwait;
  assign mem_wb_en = go;
  assign mem_wb_bubble = go & memwait;
  assign dbg_halted = state == HALTED;
  assign mem_timeout_err = state == ERROR;
  // next state and memory-wait cycle count
  always_comb begin
    state_n = state;
    wait_n = wait_cnt;
    if (active) begin
      state_n = memwait ? ((state == MEM_WAIT && wait_cnt == WW'(MEM_TIMEOUT - 1)) ? ERROR : MEM_WAIT)
                        : (dbg_halt_req ? HALTED : RUN);
      wait_n = memwait ? ((state == MEM_WAIT) ? wait_cnt + WW'(1) : WW'(1)) : '0;
    end else if (state == HALTED) begin
      state_n = dbg_halt_req ? HALTED : RUN;
    end
  end
  // state, wait counter and saturating stall counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wait_cnt <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
      if ((state == RUN || state == MEM_WAIT) && !pc_en && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scoreboard bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;
  localparam int CW = 4;
  localparam logic [7:0] NORM = 8'b11010110;
  localparam logic [7:0] LU   = 8'b00011110;
  localparam logic [7:0] BR   = 8'b11111110;
  localparam logic [7:0] MW   = 8'b00000011;
  localparam logic [7:0] ZERO = 8'b00000000;
  typedef struct {
    string tag;
    logic [7:0] ctl;
    logic h;
    logic e;
    logic [CW-1:0] st;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic clk = 0;
  logic reset = 1;
  logic [3:0] id_rn_addr, id_rm_addr, ex_rd_addr;
  logic id_rn_used, id_rm_used, ex_mem_read, ex_branch_taken;
  logic dmem_req, dmem_ready, dbg_halt_req, dbg_step;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en, mem_wb_bubble;
  logic dbg_halted, mem_timeout_err;
  logic [CW-1:0] stall_cycles;
  logic [7:0] ctl;
  always #5 clk = ~clk;
  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW), .RA_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rn_addr(id_rn_addr), .id_rm_addr(id_rm_addr),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble),
    .dbg_halted(dbg_halted), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles)
  );
  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en, mem_wb_bubble};

  task automatic idle();
    id_rn_addr = 0; id_rm_addr = 0; ex_rd_addr = 0;
    id_rn_used = 0; id_rm_used = 0; ex_mem_read = 0; ex_branch_taken = 0;
    dmem_req = 0; dmem_ready = 0; dbg_halt_req = 0; dbg_step = 0;
  endtask

  task automatic expect_out(string tag, logic [7:0] c, logic h, logic e, int st);
    exp_t x;
    x.tag = tag; x.ctl = c; x.h = h; x.e = e; x.st = CW'(st);
    sb.push_back(x);
    #1;
    x = sb.pop_front();
    vectors++;
    assert (ctl === x.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl got %b want %b", x.tag, ctl, x.ctl);
    end
    vectors++;
    assert ({dbg_halted, mem_timeout_err} === {x.h, x.e}) else begin
      miscompares++;
      $error("FAIL %s halted/err got %b%b want %b%b", x.tag, dbg_halted, mem_timeout_err, x.h, x.e);
    end
    vectors++;
    assert (stall_cycles === x.st) else begin
      miscompares++;
      $error("FAIL %s stall_cycles got %0d want %0d", x.tag, stall_cycles, x.st);
    end
  endtask

  task automatic expect_state(string tag, state_t s, int wc);
    vectors++;
    assert (dut.state === s && int'(dut.wait_cnt) === wc) else begin
      miscompares++;
      $error("FAIL %s state/wait_cnt got %0d/%0d want %0d/%0d", tag, dut.state, dut.wait_cnt, s, wc);
    end
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    expect_out("reset", ZERO, 0, 0, 0);
    expect_state("reset_st", RUN, 0);
    @(negedge clk); reset = 0;
    expect_out("idle", NORM, 0, 0, 0);
    @(negedge clk); ex_mem_read = 1; ex_rd_addr = 3; id_rn_addr = 3; id_rn_used = 1;
    expect_out("lu_rn", LU, 0, 0, 0);
    @(negedge clk); idle();
    expect_out("lu_rn_after", NORM, 0, 0, 1);
    @(negedge clk); ex_mem_read = 1; ex_rd_addr = 3; id_rn_addr = 3; id_rn_used = 0;
    expect_out("lu_unused", NORM, 0, 0, 1);
    @(negedge clk); idle(); ex_mem_read = 1; ex_rd_addr = 5; id_rm_addr = 5; id_rm_used = 1; id_rn_addr = 5;
    expect_out("lu_rm", LU, 0, 0, 1);
    @(negedge clk); idle();
    expect_out("lu_rm_after", NORM, 0, 0, 2);
    @(negedge clk); ex_mem_read = 1; ex_rd_addr = 7; id_rn_addr = 7; id_rn_used = 1; ex_branch_taken = 1;
    expect_out("br_lu", BR, 0, 0, 2);
    @(negedge clk); idle();
    expect_out("br_after", NORM, 0, 0, 2);
    @(negedge clk); dmem_req = 1;
    expect_out("mw1", MW, 0, 0, 2);
    @(negedge clk); ex_branch_taken = 1;
    expect_out("mw2_br", MW, 0, 0, 3);
    expect_state("mw2_st", MEM_WAIT, 1);
    @(negedge clk); ex_branch_taken = 0;
    expect_out("mw3", MW, 0, 0, 4);
    @(negedge clk); dmem_ready = 1;
    expect_out("mw_done", NORM, 0, 0, 5);
    expect_state("mw_done_st", MEM_WAIT, 3);
    @(negedge clk); idle();
    expect_out("mw_back", NORM, 0, 0, 5);
    expect_state("mw_back_st", RUN, 0);
    @(negedge clk); dbg_halt_req = 1;
    expect_out("halt_req", NORM, 0, 0, 5);
    @(negedge clk);
    expect_out("halted", ZERO, 1, 0, 5);
    expect_state("halted_st", HALTED, 0);
    @(negedge clk); ex_mem_read = 1; ex_rd_addr = 2; id_rn_addr = 2; id_rn_used = 1;
    expect_out("halted_lu", ZERO, 1, 0, 5);
    @(negedge clk); idle(); dbg_halt_req = 1; dbg_step = 1;
    expect_out("step", NORM, 1, 0, 5);
    @(negedge clk); dbg_step = 0;
    expect_out("step_after", ZERO, 1, 0, 5);
    @(negedge clk); dbg_halt_req = 0;
    expect_out("unhalt", ZERO, 1, 0, 5);
    @(negedge clk);
    expect_out("resumed", NORM, 0, 0, 5);
    expect_state("resumed_st", RUN, 0);
    @(negedge clk); dmem_req = 1;
    expect_out("rw1", MW, 0, 0, 5);
    @(negedge clk);
    expect_out("rw2", MW, 0, 0, 6);
    @(negedge clk); reset = 1;
    expect_out("rw_reset", ZERO, 0, 0, 7);
    expect_state("rw_reset_st", MEM_WAIT, 2);
    @(negedge clk); reset = 0; idle();
    expect_out("rw_clear", NORM, 0, 0, 0);
    expect_state("rw_clear_st", RUN, 0);
    @(negedge clk); dmem_req = 1;
    expect_out("nw1", MW, 0, 0, 0);
    @(negedge clk);
    expect_out("nw2", MW, 0, 0, 1);
    @(negedge clk); dmem_ready = 1;
    expect_out("nw_done", NORM, 0, 0, 2);
    @(negedge clk); idle();
    expect_out("nw_after", NORM, 0, 0, 2);
    @(negedge clk); dmem_req = 1;
    expect_out("to1", MW, 0, 0, 2);
    @(negedge clk);
    expect_out("to2", MW, 0, 0, 3);
    @(negedge clk);
    expect_out("to3", MW, 0, 0, 4);
    @(negedge clk);
    expect_out("to4", MW, 0, 0, 5);
    expect_state("to4_st", MEM_WAIT, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); ex_branch_taken = i[0]; dmem_ready = i[1];
      expect_out("err_hold", ZERO, 0, 1, 6);
    end
    expect_state("err_st", ERROR, 4);
    @(negedge clk); reset = 1;
    expect_out("err_reset", ZERO, 0, 1, 6);
    @(negedge clk); reset = 0; idle();
    expect_out("err_clear", NORM, 0, 0, 0);
    expect_state("err_clear_st", RUN, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ex_mem_read = 1; ex_rd_addr = 9; id_rm_addr = 9; id_rm_used = 1;
      expect_out("sat", LU, 0, 0, (i > 15) ? 15 : i);
    end
    @(negedge clk); idle();
    expect_out("sat_after", NORM, 0, 0, 15);
    @(negedge clk); dbg_halt_req = 1;
    expect_out("h2_req", NORM, 0, 0, 15);
    @(negedge clk); dbg_step = 1; dmem_req = 1;
    expect_out("h2_step_mw", MW, 1, 0, 15);
    @(negedge clk); dbg_step = 0;
    expect_out("h2_wait", MW, 0, 0, 15);
    expect_state("h2_wait_st", MEM_WAIT, 1);
    @(negedge clk); dmem_ready = 1;
    expect_out("h2_done", NORM, 0, 0, 15);
    @(negedge clk); dmem_req = 0; dmem_ready = 0;
    expect_out("h2_rehalt", ZERO, 1, 0, 15);
    @(negedge clk); dbg_halt_req = 0;
    expect_out("h2_unhalt", ZERO, 1, 0, 15);
    @(negedge clk);
    expect_out("h2_run", NORM, 0, 0, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central sequencer for the 5-stage ARM pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC.
- Generates per-stage load enables and bubble/flush controls from three sources: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory handshakes.
- Adds a memory-wait timeout trap, a debug halt/single-step handshake, and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16, max consecutive dmem wait cycles before trapping to ERROR (>=2).
- CNT_W, 16, width of the stall_cycles counter.
- RA_W, 4, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rn_addr  in  RA_W  first source register of the instruction in ID
- id_rm_addr  in  RA_W  second source register of the instruction in ID
- id_rn_used  in  1  ID instruction reads rn
- id_rm_used  in  1  ID instruction reads rm
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd_addr  in  RA_W  destination register of the instruction in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- dmem_req  in  1  MEM stage access active
- dmem_ready  in  1  data memory completes the access this cycle
- dbg_halt_req  in  1  level request to halt
- dbg_step  in  1  single-cycle pulse to advance once while halted
- pc_en  out  1  PC load enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_en  out  1  ID/EX load enable
- id_ex_bubble  out  1  ID/EX loads zeroed control signals
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_en  out  1  MEM/WB load enable
- mem_wb_bubble  out  1  MEM/WB loads zeroed control signals (reg_write_enable=0, mem_write_enable=0)
- dbg_halted  out  1  pipeline frozen under debug
- mem_timeout_err  out  1  sticky timeout trap
- stall_cycles  out  CNT_W  saturating stall counter

Behaviour:
- FSM states, held in a registered state: RUN, MEM_WAIT, HALTED, ERROR.
- Reset values: state=RUN, dbg_halted=0, mem_timeout_err=0, stall_cycles=0, wait_cnt=0.
- While reset is high, all enable, flush and bubble outputs are 0.
- Enables, flush and bubble outputs are combinational from state and inputs. Unless stated otherwise, every *_en=1 and every flush/bubble=0.
- memwait = dmem_req & ~dmem_ready.
- Priority in RUN/step cycles: memwait > ex_branch_taken > load-use.
- memwait cycle:
  - pc_en, if_id_en, id_ex_en and ex_mem_en are 0.
  - mem_wb_en=1 with mem_wb_bubble=1, so WB never repeats a write.
  - Branch and load-use requests are ignored this cycle; they persist because the stages are frozen.
- Branch taken:
  - if_id_flush=1 and id_ex_bubble=1, both loading.
  - pc_en=1 so the PC loads the branch target.
  - A simultaneous load-use hazard is discarded.
- Load-use:
  - Condition: ex_mem_read & ((id_rn_used & id_rn_addr==ex_rd_addr) | (id_rm_used & id_rm_addr==ex_rd_addr)).
  - pc_en=0, if_id_en=0, id_ex_bubble=1; EX/MEM and MEM/WB advance.
  - Lasts exactly one cycle because the load then leaves EX.
- RUN transitions:
  - memwait -> MEM_WAIT, with wait_cnt=1.
  - else dbg_halt_req -> HALTED; the current cycle still advances normally.
- MEM_WAIT:
  - Outputs follow the memwait rule while memwait holds.
  - On dmem_ready: normal advance that cycle (branch/load-use rules apply), then -> RUN.
  - While still waiting, wait_cnt increments. When wait_cnt==MEM_TIMEOUT-1 and still waiting -> ERROR.
- HALTED:
  - All enables 0, no bubbles; dbg_halted=1.
  - dbg_step=1: that cycle is evaluated exactly as a RUN cycle. If it hits memwait, go to MEM_WAIT; on completion return to HALTED if dbg_halt_req is still high.
  - dbg_halt_req=0 and no step -> RUN next cycle.
- ERROR: all enables 0, mem_timeout_err=1, left only by reset.
- stall_cycles: +1 on any cycle in RUN or MEM_WAIT where pc_en=0; saturates at 2^CNT_W-1. Not counted in HALTED or ERROR.
- Reset mid-MEM_WAIT: returns to RUN and clears wait_cnt; the outstanding access is abandoned.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, MEM_WAIT, HALTED, ERROR), RA_W, and the default MEM_TIMEOUT/CNT_W constants.
- Sub-module load_use_detect: combinational comparator producing the load-use hazard signal, reused by forwarding verification.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd_addr=3, id_rn_addr=3, id_rn_used=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=1 for exactly 1 cycle; stall_cycles 0->1. Same stimulus with id_rn_used=0 -> no stall.
- Branch + load-use same cycle -> if_id_flush=1, id_ex_bubble=1, pc_en=1; stall_cycles unchanged.
- dmem_req=1, dmem_ready=0 for 3 cycles then ready -> 3 cycles with all front enables 0 and mem_wb_bubble=1, normal advance on the 4th; state MEM_WAIT then RUN; stall_cycles=3.
- MEM_TIMEOUT=4, dmem_ready never asserted -> ERROR entered after 4 wait cycles; mem_timeout_err=1 and all enables 0 for 10 further cycles; reset clears both.
- dbg_halt_req=1 -> dbg_halted=1 next cycle and all enables 0. One dbg_step pulse -> exactly one cycle with all enables=1, then frozen again. Drop the request -> RUN.
- Reset asserted in the 2nd MEM_WAIT cycle -> outputs 0 during reset; state=RUN and wait_cnt=0 afterwards; a new 2-cycle wait does not trap.
